stream_gate: RTL and testbench

STREAM_GATE -- requirements
Module: stream_gate

---
 rtl/qci_pkg.sv | 16 +
 rtl/stream_gate_tbl.sv | 45 ++++
 rtl/stream_gate.sv | 127 ++++++++++++
 tb/tb_stream_gate.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qci_pkg.sv
// Shared widths and FSM state type for the QCI stream-gating path.
package qci_pkg;

    localparam int GATE_IDX_W  = 7;
    localparam int GATE_ID_W   = 12;
    localparam int FRAME_LEN_W = 11;
    localparam int AXIS_DATA_W = 64;
    localparam int AXIS_KEEP_W = AXIS_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } gate_state_e;

endpackage

// File: rtl/stream_gate_tbl.sv
// Per-gate state table: open flag, invalid-receive enable and latched closed flag,
// with one config write port and one decision read port.
module stream_gate_tbl
    import qci_pkg::*;
#(
    parameter int NUM_GATES = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_wr,
    input  logic [GATE_IDX_W-1:0] cfg_gate_id,
    input  logic                  cfg_open,
    input  logic                  cfg_inv_rx_en,
    input  logic [GATE_IDX_W-1:0] dec_gate_id,
    input  logic                  drop_dec,
    output logic                  dec_open,
    output logic                  dec_closed,
    output logic [NUM_GATES-1:0]  closed_inv_rx
);

    logic [NUM_GATES-1:0] gate_open;
    logic [NUM_GATES-1:0] inv_rx_en;

    // Reads see pre-write contents, so a same-cycle cfg_wr only affects later frames.
    assign dec_open   = gate_open[dec_gate_id];
    assign dec_closed = closed_inv_rx[dec_gate_id];

    // A cfg_wr colliding with a drop on the same gate leaves the flag cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_open     <= '1;
            inv_rx_en     <= '0;
            closed_inv_rx <= '0;
        end else begin
            if (drop_dec && inv_rx_en[dec_gate_id])
                closed_inv_rx[dec_gate_id] <= 1'b1;
            if (cfg_wr) begin
                gate_open[cfg_gate_id]     <= cfg_open;
                inv_rx_en[cfg_gate_id]     <= cfg_inv_rx_en;
                closed_inv_rx[cfg_gate_id] <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/stream_gate.sv
// Per-frame stream gate: passes or drops whole frames based on the gate table.
// Define STREAM_GATE_STATS_EN to add saturating pass_frames/drop_frames counters.
module stream_gate
    import qci_pkg::*;
#(
    parameter int NUM_GATES = 128
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [AXIS_DATA_W-1:0] s_axis_tdata,
    input  logic [AXIS_KEEP_W-1:0] s_axis_tkeep,
    input  logic                   s_axis_tlast,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [GATE_ID_W-1:0]   gate_id_in,
    input  logic [FRAME_LEN_W-1:0] frame_len_in,
    output logic [AXIS_DATA_W-1:0] m_axis_tdata,
    output logic [AXIS_KEEP_W-1:0] m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [GATE_ID_W-1:0]   gate_id_out,
    output logic [FRAME_LEN_W-1:0] frame_len_out,
    input  logic                   cfg_wr,
    input  logic [GATE_IDX_W-1:0]  cfg_gate_id,
    input  logic                   cfg_open,
    input  logic                   cfg_inv_rx_en,
    output logic [NUM_GATES-1:0]   closed_inv_rx
`ifdef STREAM_GATE_STATS_EN
    ,
    output logic [31:0]            pass_frames,
    output logic [31:0]            drop_frames
`endif
);

    gate_state_e state, state_nxt;

    logic first_beat;
    logic pass_dec;
    logic load;
    logic hs;
    logic decided;
    logic fwd;
    logic dec_open;
    logic dec_closed;

    stream_gate_tbl #(
        .NUM_GATES(NUM_GATES)
    ) u_tbl (
        .clk          (clk),
        .rst          (rst),
        .cfg_wr       (cfg_wr),
        .cfg_gate_id  (cfg_gate_id),
        .cfg_open     (cfg_open),
        .cfg_inv_rx_en(cfg_inv_rx_en),
        .dec_gate_id  (gate_id_in[GATE_IDX_W-1:0]),
        .drop_dec     (decided && !pass_dec),
        .dec_open     (dec_open),
        .dec_closed   (dec_closed),
        .closed_inv_rx(closed_inv_rx)
    );

    assign first_beat    = (state == IDLE) && s_axis_tvalid;
    assign pass_dec      = dec_open && !dec_closed;
    assign load          = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = load || (state == DROP) || (first_beat && !pass_dec);
    assign hs            = s_axis_tvalid && s_axis_tready;
    assign decided       = hs && (state == IDLE);
    // A forwarded beat always implies load, since pass beats only handshake on load.
    assign fwd           = hs && (((state == IDLE) && pass_dec) || (state == PASS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (hs && !s_axis_tlast) state_nxt = pass_dec ? PASS : DROP;
            PASS,
            DROP: if (hs && s_axis_tlast) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            gate_id_out   <= '0;
            frame_len_out <= '0;
        end else begin
            if (fwd) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= s_axis_tdata;
                m_axis_tkeep  <= s_axis_tkeep;
                m_axis_tlast  <= s_axis_tlast;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            if (decided && pass_dec) begin
                gate_id_out   <= gate_id_in;
                frame_len_out <= frame_len_in;
            end
        end
    end

`ifdef STREAM_GATE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_frames <= '0;
            drop_frames <= '0;
        end else if (decided) begin
            if (pass_dec && (pass_frames != '1))
                pass_frames <= pass_frames + 32'd1;
            if (!pass_dec && (drop_frames != '1))
                drop_frames <= drop_frames + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stream_gate.sv
// Scoreboard bench for stream_gate; build with STREAM_GATE_STATS_EN to also cover the counters.
module tb_stream_gate;
    import qci_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] s_axis_tdata = '0;
    logic [7:0]  s_axis_tkeep = '0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [11:0] gate_id_in = '0;
    logic [10:0] frame_len_in = '0;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic [11:0] gate_id_out;
    logic [10:0] frame_len_out;
    logic        cfg_wr = 1'b0;
    logic [6:0]  cfg_gate_id = '0;
    logic        cfg_open = 1'b0;
    logic        cfg_inv_rx_en = 1'b0;
    logic [127:0] closed_inv_rx;
`ifdef STREAM_GATE_STATS_EN
    logic [31:0] pass_frames;
    logic [31:0] drop_frames;
`endif

    stream_gate #(.NUM_GATES(128)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .gate_id_in(gate_id_in), .frame_len_in(frame_len_in),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .gate_id_out(gate_id_out), .frame_len_out(frame_len_out),
        .cfg_wr(cfg_wr), .cfg_gate_id(cfg_gate_id), .cfg_open(cfg_open),
        .cfg_inv_rx_en(cfg_inv_rx_en), .closed_inv_rx(closed_inv_rx)
`ifdef STREAM_GATE_STATS_EN
        , .pass_frames(pass_frames), .drop_frames(drop_frames)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [11:0] gid;
        logic [10:0] flen;
        int unsigned cyc;
    } beat_t;

    beat_t       sb[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc = 0;
    bit          bp_en = 1'b0;

    bit          model_open[128];
    bit          model_inv[128];
    bit          model_closed[128];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (bp_en) m_axis_tready = ~m_axis_tready;
    end

    bit          held = 1'b0;
    beat_t       snap;
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else if (m_axis_tvalid) begin
            if (held) begin
                check("stable_data", m_axis_tdata, snap.data);
                check("stable_last", {63'd0, m_axis_tlast}, {63'd0, snap.last});
            end else if (sb.size() > 0) begin
                check("latency", 64'(cyc), 64'(sb[0].cyc + 1));
            end
            if (m_axis_tready) begin
                held = 1'b0;
                if (sb.size() == 0) begin
                    check("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    check("tdata", m_axis_tdata, e.data);
                    check("tkeep", {56'd0, m_axis_tkeep}, {56'd0, e.keep});
                    check("tlast", {63'd0, m_axis_tlast}, {63'd0, e.last});
                    check("gate_id_out", {52'd0, gate_id_out}, {52'd0, e.gid});
                    check("frame_len_out", {53'd0, frame_len_out}, {53'd0, e.flen});
                end
            end else begin
                held = 1'b1;
                snap.data = m_axis_tdata;
                snap.last = m_axis_tlast;
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 128; i++) begin
            model_open[i] = 1'b1;
            model_inv[i] = 1'b0;
            model_closed[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        #1;
        check("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        check("rst_tdata", m_axis_tdata, 64'd0);
        check("rst_tlast", {63'd0, m_axis_tlast}, 64'd0);
        check("rst_gate_id_out", {52'd0, gate_id_out}, 64'd0);
        check("rst_frame_len_out", {53'd0, frame_len_out}, 64'd0);
        check("rst_closed_lo", closed_inv_rx[63:0], 64'd0);
`ifdef STREAM_GATE_STATS_EN
        check("rst_pass_frames", {32'd0, pass_frames}, 64'd0);
        check("rst_drop_frames", {32'd0, drop_frames}, 64'd0);
`endif
        sb.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic cfg_write(input logic [6:0] g, input bit open_v, input bit inv_v);
        @(negedge clk);
        cfg_wr = 1'b1;
        cfg_gate_id = g;
        cfg_open = open_v;
        cfg_inv_rx_en = inv_v;
        @(posedge clk);
        #1;
        cfg_wr = 1'b0;
        model_open[g] = open_v;
        model_inv[g] = inv_v;
        model_closed[g] = 1'b0;
    endtask

    task automatic send_frame(input logic [11:0] gid, input int unsigned nb,
                              input bit cfg_same, input bit cfg_open_v, input int abort_at);
        bit          pass = 1'b0;
        int unsigned waited;
        logic [6:0]  g;
        logic [10:0] flen;
        g = gid[6:0];
        flen = 11'(nb * 8);
        for (int unsigned b = 0; b < nb; b++) begin
            if (abort_at == int'(b)) begin
                do_reset();
                return;
            end
            @(negedge clk);
            s_axis_tvalid = 1'b1;
            s_axis_tdata = {$urandom, $urandom};
            s_axis_tkeep = (b == nb - 1) ? 8'h0F : 8'hFF;
            s_axis_tlast = (b == nb - 1);
            gate_id_in = gid;
            frame_len_in = flen;
            if (b == 0 && cfg_same) begin
                cfg_wr = 1'b1;
                cfg_gate_id = g;
                cfg_open = cfg_open_v;
                cfg_inv_rx_en = 1'b0;
            end
            if (b == 0) pass = model_open[g] && !model_closed[g];
            #1;
            if (!pass) check("drop_tready", {63'd0, s_axis_tready}, 64'd1);
            waited = 0;
            while (!s_axis_tready && waited < 50) begin
                @(negedge clk);
                #1;
                waited++;
            end
            if (waited >= 50) begin
                check("ready_timeout", 64'd1, 64'd0);
                s_axis_tvalid = 1'b0;
                return;
            end
            if (pass) sb.push_back('{s_axis_tdata, s_axis_tkeep, s_axis_tlast, gid, flen, cyc});
            @(posedge clk);
            #1;
            cfg_wr = 1'b0;
            if (b == 0) begin
                if (!pass && model_inv[g]) model_closed[g] = 1'b1;
                if (cfg_same) begin
                    model_open[g] = cfg_open_v;
                    model_inv[g] = 1'b0;
                    model_closed[g] = 1'b0;
                end
            end
        end
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        #1;
        check("closed_flag", {63'd0, closed_inv_rx[g]}, {63'd0, model_closed[g]});
    endtask

    task automatic drain();
        int unsigned n = 0;
        while ((sb.size() != 0 || m_axis_tvalid) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        model_reset();
        do_reset();

        // default open gate
        send_frame(12'd5, 8, 1'b0, 1'b0, -1);
        drain();
        check("gid_after_default", {52'd0, gate_id_out}, 64'd5);

        // closed gate, then a different gate passes
        cfg_write(7'd5, 1'b0, 1'b0);
        send_frame(12'd5, 4, 1'b0, 1'b0, -1);
        drain();
        check("gid_held_after_drop", {52'd0, gate_id_out}, 64'd5);
        send_frame(12'd6, 3, 1'b0, 1'b0, -1);
        drain();
        check("gid_after_gate6", {52'd0, gate_id_out}, 64'd6);

        // invalid receive latch and clear
        cfg_write(7'd3, 1'b0, 1'b1);
        send_frame(12'd3, 2, 1'b0, 1'b0, -1);
        drain();
        check("inv_rx_set", {63'd0, closed_inv_rx[3]}, 64'd1);
        cfg_write(7'd3, 1'b1, 1'b0);
        check("inv_rx_cleared", {63'd0, closed_inv_rx[3]}, 64'd0);
        send_frame(12'd3, 2, 1'b0, 1'b0, -1);
        drain();

        // single-beat frames, pass and drop
        send_frame(12'd7, 1, 1'b0, 1'b0, -1);
        send_frame(12'd5, 1, 1'b0, 1'b0, -1);
        drain();
        check("gid_single", {52'd0, gate_id_out}, 64'd7);

        // same-cycle config write uses pre-write gate state
        send_frame(12'd2, 3, 1'b1, 1'b0, -1);
        drain();
        send_frame(12'd2, 2, 1'b0, 1'b0, -1);
        drain();
        check("gid_same_cycle", {52'd0, gate_id_out}, 64'd2);

        // backpressure 1010
        @(posedge clk);
        #1;
        m_axis_tready = 1'b1;
        bp_en = 1'b1;
        send_frame(12'd9, 4, 1'b0, 1'b0, -1);
        drain();
        bp_en = 1'b0;
        @(posedge clk);
        #2;
        m_axis_tready = 1'b1;

        // reset in the middle of a frame
        send_frame(12'd10, 6, 1'b0, 1'b0, 3);
        send_frame(12'd11, 4, 1'b0, 1'b0, -1);
        drain();
        check("gid_after_reset", {52'd0, gate_id_out}, 64'd11);
`ifdef STREAM_GATE_STATS_EN
        check("pass_frames", {32'd0, pass_frames}, 64'd1);
        check("drop_frames", {32'd0, drop_frames}, 64'd0);
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
